// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 pipeline controller: opcodes, FSM states and
// data-memory access encodings.
package lc3_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OpBr  = 4'b0000;
  localparam opcode_t OpAdd = 4'b0001;
  localparam opcode_t OpLd  = 4'b0010;
  localparam opcode_t OpSt  = 4'b0011;
  localparam opcode_t OpAnd = 4'b0101;
  localparam opcode_t OpLdr = 4'b0110;
  localparam opcode_t OpStr = 4'b0111;
  localparam opcode_t OpNot = 4'b1001;
  localparam opcode_t OpLdi = 4'b1010;
  localparam opcode_t OpSti = 4'b1011;
  localparam opcode_t OpJmp = 4'b1100;

  typedef enum logic [2:0] {
    StRst,
    StRun,
    StBrWait,
    StMemRd,
    StMemWr,
    StMemInd
  } state_e;

  typedef enum logic [1:0] {
    MemRead     = 2'd0,
    MemWrite    = 2'd1,
    MemIndirect = 2'd2,
    MemIdle     = 2'd3
  } mem_state_e;

  // Branch resolves on the third BR_WAIT cycle, when the counter reads 1.
  localparam logic [1:0] BrCountLoad = 2'd3;

  function automatic logic is_alu(input opcode_t op);
    return (op == OpAdd) || (op == OpAnd) || (op == OpNot);
  endfunction

endpackage

// File: rtl/lc3_controller_if.sv
// Controller <-> datapath bundle: pipeline status in, stage enables and memory
// access type out.
interface lc3_controller_if;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] Imem_dout;
  logic [15:0] IR;
  logic [15:0] IR_Exec;
  logic [2:0]  NZP;
  logic [2:0]  psr;
  logic        enable_updatePC;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        br_taken;
  logic [1:0]  mem_state;
  logic        bypass_alu_1;
  logic        bypass_alu_2;

  modport master (
    input  complete_instr, complete_data, Imem_dout, IR, IR_Exec, NZP, psr,
    output enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
    output br_taken, mem_state, bypass_alu_1, bypass_alu_2
  );

  modport slave (
    output complete_instr, complete_data, Imem_dout, IR, IR_Exec, NZP, psr,
    input  enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
    input  br_taken, mem_state, bypass_alu_1, bypass_alu_2
  );
endinterface

// File: rtl/lc3_hazard_detect.sv
// Combinational opcode classification of the fetch/execute instructions and the
// execute-to-decode operand forwarding compare.
module lc3_hazard_detect
  import lc3_pkg::*;
(
  input  logic [15:0] i_imem_dout,
  input  logic [15:0] i_ir,
  input  logic [15:0] i_ir_exec,
  output logic        o_is_mem_read,
  output logic        o_is_mem_write,
  output logic        o_is_mem_ind,
  output logic        o_is_ldi,
  output logic        o_is_branch,
  output logic        o_bypass_alu_1,
  output logic        o_bypass_alu_2
);

  opcode_t w_fetch_op;
  opcode_t w_ir_op;
  opcode_t w_exec_op;
  logic    w_ir_reg_form;
  logic    w_unused;

  assign w_fetch_op = i_imem_dout[15:12];
  assign w_ir_op    = i_ir[15:12];
  assign w_exec_op  = i_ir_exec[15:12];

  // Operand fields that play no part in classification.
  assign w_unused = ^{i_imem_dout[11:0], i_ir[11:9], i_ir[4:3], i_ir_exec[8:0]};

  assign o_is_mem_read  = (w_exec_op == OpLd)  || (w_exec_op == OpLdr);
  assign o_is_mem_write = (w_exec_op == OpSt)  || (w_exec_op == OpStr);
  assign o_is_mem_ind   = (w_exec_op == OpLdi) || (w_exec_op == OpSti);
  assign o_is_ldi       = (w_exec_op == OpLdi);
  assign o_is_branch    = (w_fetch_op == OpBr) || (w_fetch_op == OpJmp);

  // SR2 only exists for register-form ADD/AND (IR[5] clear).
  assign w_ir_reg_form  = ((w_ir_op == OpAdd) || (w_ir_op == OpAnd)) && !i_ir[5];

  assign o_bypass_alu_1 = is_alu(w_exec_op) && (i_ir_exec[11:9] == i_ir[8:6]);
  assign o_bypass_alu_2 = is_alu(w_exec_op) && w_ir_reg_form &&
                          (i_ir_exec[11:9] == i_ir[2:0]);

endmodule

// File: rtl/lc3_controller.sv
// LC-3 pipeline controller: stalls for data memory, waits out branch resolution
// and forwards execute results. Stage enables are registered; bypass is not.
module lc3_controller
  import lc3_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  lc3_controller_if.master io_bus
);

  state_e     r_state, w_state_next;
  logic [1:0] r_br_count, w_br_count_next;

  logic       r_en_update_pc, w_en_update_pc;
  logic       r_en_fetch, w_en_fetch;
  logic       r_en_decode, w_en_decode;
  logic       r_en_execute, w_en_execute;
  logic       r_en_writeback, w_en_writeback;
  logic       r_br_taken, w_br_taken;
  mem_state_e r_mem_state, w_mem_state;

  logic w_is_mem_read, w_is_mem_write, w_is_mem_ind, w_is_ldi, w_is_branch;
  logic w_bypass_1, w_bypass_2, w_fwd_ok;

  lc3_hazard_detect u_hazard_detect (
    .i_imem_dout   (io_bus.Imem_dout),
    .i_ir          (io_bus.IR),
    .i_ir_exec     (io_bus.IR_Exec),
    .o_is_mem_read (w_is_mem_read),
    .o_is_mem_write(w_is_mem_write),
    .o_is_mem_ind  (w_is_mem_ind),
    .o_is_ldi      (w_is_ldi),
    .o_is_branch   (w_is_branch),
    .o_bypass_alu_1(w_bypass_1),
    .o_bypass_alu_2(w_bypass_2)
  );

  always_comb begin
    w_state_next    = r_state;
    w_br_count_next = r_br_count;
    w_en_update_pc  = 1'b0;
    w_en_fetch      = 1'b0;
    w_en_decode     = 1'b0;
    w_en_execute    = 1'b0;
    w_en_writeback  = 1'b0;
    w_br_taken      = 1'b0;
    w_mem_state     = MemIdle;

    unique case (r_state)
      StRst: w_state_next = StRun;

      StRun: begin
        if (io_bus.complete_instr) begin
          w_en_update_pc = 1'b1;
          w_en_fetch     = 1'b1;
          w_en_decode    = 1'b1;
          w_en_execute   = 1'b1;
          w_en_writeback = 1'b1;
        end
        // Memory wins; a pending branch is caught again since Imem_dout holds.
        if (w_is_mem_read) begin
          w_state_next = StMemRd;
        end else if (w_is_mem_write) begin
          w_state_next = StMemWr;
        end else if (w_is_mem_ind) begin
          w_state_next = StMemInd;
        end else if (io_bus.complete_instr && w_is_branch) begin
          w_state_next    = StBrWait;
          w_br_count_next = BrCountLoad;
        end
      end

      StBrWait: begin
        w_en_decode     = 1'b1;
        w_en_execute    = 1'b1;
        w_en_writeback  = 1'b1;
        w_br_count_next = r_br_count - 2'd1;
        if (r_br_count == 2'd1) begin
          w_en_update_pc = 1'b1;
          w_br_taken     = |(io_bus.NZP & io_bus.psr);
          w_state_next   = StRun;
        end
      end

      StMemRd: begin
        w_mem_state = MemRead;
        if (io_bus.complete_data) begin
          w_en_writeback = 1'b1;
          w_state_next   = StRun;
        end
      end

      StMemWr: begin
        w_mem_state = MemWrite;
        if (io_bus.complete_data) w_state_next = StRun;
      end

      StMemInd: begin
        w_mem_state = MemIndirect;
        if (io_bus.complete_data) w_state_next = w_is_ldi ? StMemRd : StMemWr;
      end

      default: w_state_next = StRst;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= StRst;
      r_br_count     <= 2'd0;
      r_en_update_pc <= 1'b0;
      r_en_fetch     <= 1'b0;
      r_en_decode    <= 1'b0;
      r_en_execute   <= 1'b0;
      r_en_writeback <= 1'b0;
      r_br_taken     <= 1'b0;
      r_mem_state    <= MemIdle;
    end else begin
      r_state        <= w_state_next;
      r_br_count     <= w_br_count_next;
      r_en_update_pc <= w_en_update_pc;
      r_en_fetch     <= w_en_fetch;
      r_en_decode    <= w_en_decode;
      r_en_execute   <= w_en_execute;
      r_en_writeback <= w_en_writeback;
      r_br_taken     <= w_br_taken;
      r_mem_state    <= w_mem_state;
    end
  end

  assign w_fwd_ok = (r_state == StRun) || (r_state == StBrWait);

  assign io_bus.enable_updatePC  = r_en_update_pc;
  assign io_bus.enable_fetch     = r_en_fetch;
  assign io_bus.enable_decode    = r_en_decode;
  assign io_bus.enable_execute   = r_en_execute;
  assign io_bus.enable_writeback = r_en_writeback;
  assign io_bus.br_taken         = r_br_taken;
  assign io_bus.mem_state        = r_mem_state;
  assign io_bus.bypass_alu_1     = w_bypass_1 & w_fwd_ok;
  assign io_bus.bypass_alu_2     = w_bypass_2 & w_fwd_ok;

endmodule

// File: tb/tb_lc3_controller.sv
// Directed bench for lc3_controller: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_lc3_controller;

  logic clock;
  logic reset;

  lc3_controller_if bus ();

  lc3_controller u_dut (
    .clock (clock),
    .reset (reset),
    .io_bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {upc, fetch, decode, execute, writeback, br_taken, mem_state[1:0], byp1, byp2}
  localparam logic [9:0] OIdle   = 10'b00000_0_11_00;
  localparam logic [9:0] ORun    = 10'b11111_0_11_00;
  localparam logic [9:0] ORd     = 10'b00000_0_00_00;
  localparam logic [9:0] ORdDone = 10'b00001_0_00_00;
  localparam logic [9:0] OWr     = 10'b00000_0_01_00;
  localparam logic [9:0] OInd    = 10'b00000_0_10_00;
  localparam logic [9:0] OBrw    = 10'b00111_0_11_00;
  localparam logic [9:0] OBrNt   = 10'b10111_0_11_00;
  localparam logic [9:0] OBrT    = 10'b10111_1_11_00;

  localparam logic [15:0] IAdd     = 16'h1283;  // ADD R1,R2,R3
  localparam logic [15:0] IAddR5   = 16'h1B87;  // ADD R5,R6,R7
  localparam logic [15:0] IAddR3   = 16'h1600;  // ADD R3,R0,R0
  localparam logic [15:0] IAddR4   = 16'h1800;  // ADD R4,R0,R0
  localparam logic [15:0] IUseR3   = 16'h12C3;  // ADD R1,R3,R3
  localparam logic [15:0] IUseR3Im = 16'h12E3;  // ADD R1,R3,#3
  localparam logic [15:0] INotR3   = 16'h97FF;  // NOT R3,R7
  localparam logic [15:0] IAndR3   = 16'h5600;  // AND R3,R0,R0
  localparam logic [15:0] IAndUse  = 16'h52C2;  // AND R1,R3,R2
  localparam logic [15:0] ILdr     = 16'h6A40;
  localparam logic [15:0] ILd      = 16'h2000;
  localparam logic [15:0] ISti     = 16'hB000;
  localparam logic [15:0] IBrz     = 16'h0402;

  typedef struct {
    int         cyc;
    string      name;
    logic [9:0] mask;
    logic [9:0] val;
  } exp_t;

  exp_t       q[$];
  exp_t       cur;
  logic [9:0] got;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      cur = q.pop_front();
      got = {bus.enable_updatePC, bus.enable_fetch, bus.enable_decode, bus.enable_execute,
             bus.enable_writeback, bus.br_taken, bus.mem_state, bus.bypass_alu_1,
             bus.bypass_alu_2};
      n_cmp++;
      if ((got & cur.mask) !== (cur.val & cur.mask)) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got=%b want=%b mask=%b", cur.name, cyc, got & cur.mask,
                 cur.val & cur.mask, cur.mask);
      end
    end
  end

  // Inputs are already applied; queue the bypass result for this cycle and the
  // registered outputs that appear after the coming edge.
  task automatic step(input string nm, input logic [9:0] regs, input logic [1:0] byp);
    exp_t e;
    e.cyc  = cyc;
    e.name = {nm, "_byp"};
    e.mask = 10'h003;
    e.val  = {8'b0, byp};
    q.push_back(e);
    e.cyc  = cyc + 1;
    e.name = nm;
    e.mask = 10'h3FC;
    e.val  = regs;
    q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic add_stream();
    bus.Imem_dout = IAdd;
    bus.IR        = IAdd;
    bus.IR_Exec   = IAddR5;
  endtask

  initial begin
    reset                  = 1'b1;
    bus.complete_instr     = 1'b0;
    bus.complete_data      = 1'b0;
    bus.NZP                = 3'b000;
    bus.psr                = 3'b000;
    add_stream();
    @(posedge clock);
    #1;
    step("reset_hold", OIdle, 2'b00);

    reset = 1'b0;
    bus.complete_instr = 1'b1;
    step("rst_state", OIdle, 2'b00);
    step("run_add", ORun, 2'b00);
    step("run_add2", ORun, 2'b00);

    // LDR: three MEM_RD cycles, data completes on the third.
    bus.IR_Exec = ILdr;
    step("ldr_issue", ORun, 2'b00);
    step("ldr_wait1", ORd, 2'b00);
    bus.IR_Exec = IAddR3;
    bus.IR      = IUseR3;
    step("ldr_wait2_byp_gate", ORd, 2'b00);
    add_stream();
    bus.complete_data = 1'b1;
    step("ldr_done", ORdDone, 2'b00);
    bus.complete_data = 1'b0;
    step("ldr_back_run", ORun, 2'b00);

    // STI: indirect read, then write.
    bus.IR_Exec = ISti;
    step("sti_issue", ORun, 2'b00);
    step("sti_ind_wait", OInd, 2'b00);
    bus.complete_data = 1'b1;
    step("sti_ind_done", OInd, 2'b00);
    bus.complete_data = 1'b0;
    step("sti_wr_wait", OWr, 2'b00);
    bus.complete_data = 1'b1;
    step("sti_wr_done", OWr, 2'b00);
    bus.complete_data = 1'b0;
    add_stream();
    step("sti_back_run", ORun, 2'b00);

    // BRz taken, then not taken.
    for (int k = 0; k < 2; k++) begin
      bus.Imem_dout = IBrz;
      bus.NZP       = 3'b010;
      bus.psr       = (k == 0) ? 3'b010 : 3'b100;
      step("brz_issue", ORun, 2'b00);
      bus.Imem_dout = IAdd;
      step("brz_wait3", OBrw, 2'b00);
      bus.IR_Exec = IAddR3;
      bus.IR      = IUseR3;
      step("brz_wait2_byp", OBrw, 2'b11);
      add_stream();
      step((k == 0) ? "brz_taken" : "brz_not_taken", (k == 0) ? OBrT : OBrNt, 2'b00);
      step("brz_back_run", ORun, 2'b00);
    end

    // Memory beats branch; branch is re-detected afterwards.
    bus.Imem_dout = IBrz;
    bus.IR_Exec   = ILd;
    bus.NZP       = 3'b111;
    bus.psr       = 3'b001;
    step("prio_issue", ORun, 2'b00);
    bus.IR_Exec       = IAddR5;
    bus.complete_data = 1'b1;
    step("prio_ld_done", ORdDone, 2'b00);
    bus.complete_data = 1'b0;
    step("prio_br_redetect", ORun, 2'b00);
    bus.Imem_dout = IAdd;
    step("prio_wait3", OBrw, 2'b00);
    step("prio_wait2", OBrw, 2'b00);
    step("prio_jmp_taken", OBrT, 2'b00);
    step("prio_back_run", ORun, 2'b00);

    // Forwarding compares in RUN.
    bus.IR_Exec = IAddR3;
    bus.IR      = IUseR3;
    step("byp_both", ORun, 2'b11);
    bus.IR = IUseR3Im;
    step("byp_imm", ORun, 2'b10);
    bus.IR_Exec = INotR3;
    bus.IR      = IUseR3;
    step("byp_not", ORun, 2'b11);
    bus.IR_Exec = IAddR4;
    step("byp_none", ORun, 2'b00);
    bus.IR_Exec = IAndR3;
    bus.IR      = IAndUse;
    step("byp_and", ORun, 2'b10);

    // Reset from RUN with a live hazard: bypass gated once in RST.
    bus.IR_Exec = IAddR3;
    bus.IR      = IUseR3;
    reset       = 1'b1;
    step("rst_from_run", OIdle, 2'b11);
    reset = 1'b0;
    step("rst_gate_byp", OIdle, 2'b00);
    add_stream();
    step("rst_run", ORun, 2'b00);

    // Reset during MEM_RD overrides complete_data.
    bus.IR_Exec = ILd;
    step("g_ld_issue", ORun, 2'b00);
    bus.IR_Exec = IAddR5;
    step("g_rd_wait", ORd, 2'b00);
    reset             = 1'b1;
    bus.complete_data = 1'b1;
    step("g_rd_reset", OIdle, 2'b00);
    reset = 1'b0;
    step("g_rst1", OIdle, 2'b00);
    bus.complete_data = 1'b0;
    step("g_run", ORun, 2'b00);

    // Reset during BR_WAIT.
    bus.Imem_dout = IBrz;
    bus.NZP       = 3'b010;
    bus.psr       = 3'b010;
    step("g_br_issue", ORun, 2'b00);
    bus.Imem_dout = IAdd;
    step("g_br_wait3", OBrw, 2'b00);
    reset = 1'b1;
    step("g_br_reset", OIdle, 2'b00);
    reset = 1'b0;
    step("g_rst2", OIdle, 2'b00);
    bus.complete_instr = 1'b0;
    step("g_run_stall", OIdle, 2'b00);
    bus.complete_instr = 1'b1;
    step("g_run_go", ORun, 2'b00);

    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
